// File: rtl/fix_to_fix_pipe.sv
// fix_to_fix_pipe: two-stage valid/ready signed fixed-point format converter with per-sample rounding and saturation
module fix_to_fix_pipe #(
  parameter int N_INT_IN   = 8,
  parameter int N_MANT_IN  = 8,
  parameter int N_INT_OUT  = 4,
  parameter int N_MANT_OUT = 4,
  parameter int N_CH       = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [N_CH*(N_INT_IN+N_MANT_IN+1)-1:0]      in_data,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [1:0]                                  round_mode,
  input  logic                                        sat_en,
  output logic [N_CH*(N_INT_OUT+N_MANT_OUT+1)-1:0]    out_data,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [N_CH-1:0]                             out_ovf,
  output logic                                        ovf_sticky,
  input  logic                                        clr_ovf
);
  localparam int WI = N_INT_IN + N_MANT_IN + 1;
  localparam int WO = N_INT_OUT + N_MANT_OUT + 1;
  localparam int D  = N_MANT_IN - N_MANT_OUT;
  localparam int WR = WI + 2;
  localparam logic signed [WR-1:0] MAX_O = WR'(2**(WO-1) - 1);
  localparam logic signed [WR-1:0] MIN_O = -MAX_O - WR'(1);
  logic                 s1_valid, s1_sat, s2_load;
  logic [N_CH*WR-1:0]   rnd, s1_r;
  logic [N_CH*WO-1:0]   sat_d;
  logic [N_CH-1:0]      ovf;
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    logic signed [WR-1:0] v, r, q;
    logic                 hi, lo;
    assign v = {{2{in_data[g*WI+WI-1]}}, in_data[g*WI +: WI]};
    if (D > 0) begin : g_rnd
      localparam logic signed [WR-1:0] HALF    = WR'(2**(D-1));
      localparam logic signed [WR-1:0] HALF_M1 = WR'(2**(D-1) - 1);
      logic signed [WR-1:0] bias;
      // mode 2 adds half-minus-one plus the kept LSB so exact ties land on even
      assign bias = round_mode == 2'd1 ? HALF : round_mode == 2'd2 ? HALF_M1 + WR'(v[D]) : '0;
      assign r = (v + bias) >>> D;
    end else begin : g_exact
      assign r = v <<< (-D);
    end
    assign rnd[g*WR +: WR] = r;
    assign q  = s1_r[g*WR +: WR];
    assign hi = q > MAX_O;
    assign lo = q < MIN_O;
    assign ovf[g] = hi | lo;
    assign sat_d[g*WO +: WO] = s1_sat && hi ? MAX_O[WO-1:0] : s1_sat && lo ? MIN_O[WO-1:0] : q[WO-1:0];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid   <= 1'b0;
      s1_sat     <= 1'b0;
      s1_r       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ovf    <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_r   <= rnd;
          s1_sat <= sat_en;
        end
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= sat_d;
          out_ovf  <= ovf;
        end
      end
      ovf_sticky <= (out_valid && out_ready && |out_ovf) || (ovf_sticky && !clr_ovf);
    end
  end
endmodule

// File: tb/tb_fix_to_fix_pipe.sv
// tb_fix_to_fix_pipe: scoreboard bench for fix_to_fix_pipe against an integer-arithmetic reference model
module tb_fix_to_fix_pipe;
  typedef struct {
    logic [17:0] d;
    logic [1:0]  o;
  } exp_t;
  logic        clk = 0, rst = 0;
  logic [33:0] in_data = '0;
  logic        in_valid = 0, in_ready;
  logic [1:0]  round_mode = 0;
  logic        sat_en = 0;
  logic [17:0] out_data;
  logic        out_valid, out_ready = 1;
  logic [1:0]  out_ovf;
  logic        ovf_sticky, clr_ovf = 0;
  int          checks = 0, failures = 0;
  exp_t        sb[$];
  exp_t        e;
  bit          povf, prev_stall = 0, rdone = 0;
  logic        exp_sticky = 0;
  logic [17:0] prev_d;
  logic [1:0]  prev_o;

  fix_to_fix_pipe dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .round_mode(round_mode), .sat_en(sat_en), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, req);
    end
  endtask

  // Floor division by 16, then the rounding rule applied to the remainder
  function automatic int rnd_q(input int v, input int m);
    int q, rem;
    q = v / 16;
    if (v % 16 != 0 && v < 0) q = q - 1;
    rem = v - 16 * q;
    if (m == 1 && rem >= 8) q++;
    if (m == 2 && (rem > 8 || (rem == 8 && q % 2 != 0))) q++;
    return q;
  endfunction

  function automatic exp_t model(input logic [33:0] d, input logic [1:0] m, input bit s);
    exp_t r;
    for (int l = 0; l < 2; l++) begin
      int v, q;
      v = l == 0 ? int'($signed(d[16:0])) : int'($signed(d[33:17]));
      q = rnd_q(v, int'(m));
      r.o[l] = q > 255 || q < -256;
      r.d[l*9 +: 9] = (s && q > 255) ? 9'h0FF : (s && q < -256) ? 9'h100 : 9'(q);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      exp_sticky = 0;
      prev_stall = 0;
    end else begin
      povf = 0;
      chk("sticky", ovf_sticky, exp_sticky);
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_ovf, out_data}, {prev_o, prev_d});
      end
      if (in_valid && in_ready) sb.push_back(model(in_data, round_mode, sat_en));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%0h expected=none", out_data);
        end else begin
          e = sb.pop_front();
          chk("sb_data", out_data, e.d);
          chk("sb_ovf", out_ovf, e.o);
          povf = |e.o;
        end
      end
      exp_sticky = povf || (exp_sticky && !clr_ovf);
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_o = out_ovf;
    end
  end

  task automatic send(input int a, input int b, input int m, input bit s);
    bit r;
    in_data = {17'(b), 17'(a)};
    round_mode = 2'(m);
    sat_en = s;
    in_valid = 1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk); #1;
      r = in_ready;
      @(posedge clk); #1;
      if (r) return;
    end
    checks++;
    failures++;
    $display("FAIL send_timeout actual=stalled expected=accepted");
  endtask

  task automatic single(input int a, input int b, input int m, input bit s,
                        input logic [8:0] e0, input logic [8:0] e1, input logic [1:0] eo);
    send(a, b, m, s);
    in_valid = 0;
    chk("lat_early", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_valid", out_valid, 1);
    chk("lane0", out_data[8:0], e0);
    chk("lane1", out_data[17:9], e1);
    chk("ovf", out_ovf, eo);
    @(posedge clk); #1;
  endtask

  function automatic int rv();
    return $urandom_range(0, 1) ? int'($urandom_range(0, 131071)) - 65536
                                : int'($urandom_range(0, 8191)) - 4096;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", out_ovf, 0);
    chk("rst_sticky", ovf_sticky, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1;
    @(posedge clk); #1;
    single(40, -24, 0, 0, 9'h002, 9'h1FE, 2'b00);
    single(40, -24, 1, 0, 9'h003, 9'h1FF, 2'b00);
    single(40, -24, 2, 0, 9'h002, 9'h1FE, 2'b00);
    single(24, -40, 2, 0, 9'h002, 9'h1FE, 2'b00);
    single(25600, -25600, 0, 1, 9'h0FF, 9'h100, 2'b11);
    chk("sticky_set", ovf_sticky, 1);
    single(25600, -25600, 0, 0, 9'h040, 9'h1C0, 2'b11);
    clr_ovf = 1;
    @(posedge clk); #1;
    clr_ovf = 0;
    chk("sticky_clr", ovf_sticky, 0);
    send(25600, 0, 0, 1);
    in_valid = 0;
    @(posedge clk); #1;
    clr_ovf = 1;
    @(posedge clk); #1;
    clr_ovf = 0;
    chk("clr_vs_set", ovf_sticky, 1);
    send(40, -24, 1, 0);
    send(40, -24, 0, 0);
    in_valid = 0;
    chk("mode_first_valid", out_valid, 1);
    chk("mode_first", out_data[8:0], 9'h003);
    @(posedge clk); #1;
    chk("mode_second", out_data[8:0], 9'h002);
    @(posedge clk); #1;
    fork
      begin
        for (int k = 1; k <= 6; k++) send(16 * k, -16 * k, 0, 0);
        in_valid = 0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        repeat (2) @(posedge clk);
        #1 chk("bp_in_ready", in_ready, 0);
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained", sb.size(), 0);
    send(25600, 25600, 0, 1);
    send(100, 100, 0, 0);
    in_valid = 0;
    rst = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ovf", out_ovf, 0);
    chk("mid_rst_sticky", ovf_sticky, 0);
    chk("mid_rst_data", out_data, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    chk("post_rst_idle", out_valid, 0);
    single(48, -48, 0, 0, 9'h003, 9'h1FD, 2'b00);
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send(rv(), rv(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 0;
            @(posedge clk); #1;
          end
        end
        in_valid = 0;
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          out_ready = $urandom_range(0, 3) != 0;
          clr_ovf = $urandom_range(0, 7) == 0;
        end
        out_ready = 1;
        clr_ovf = 0;
      end
    join
    for (int n = 0; n < 50 && sb.size() != 0; n++) @(posedge clk);
    #1;
    chk("final_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
